// File: rtl/veggie_pkg.sv
// Shared types and constants for the frame buffer fill path.
// Geometry, command/state/status enums and the row address helper.
package veggie_pkg;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int CRD_W  = 10;

  typedef enum logic {
    OP_CLEAR = 1'b0,
    OP_RECT  = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_EMPTY = 2'b01,
    ST_ABORT = 2'b10
  } status_t;

  // y*640 as (y*512)+(y*128), shift-add only
  function automatic logic [ADDR_W-1:0] row_base(
    input logic [CRD_W-1:0] y
  );
    logic [ADDR_W-1:0] ye;
    ye = ADDR_W'(y);
    return (ye << 9) + (ye << 7);
  endfunction

endpackage

// File: rtl/rect_clipper.sv
// Clips a rectangle to the visible frame.
// Produces exclusive end coordinates and an empty flag.
module rect_clipper
  import veggie_pkg::*;
(
  input  logic [CRD_W-1:0] x,
  input  logic [CRD_W-1:0] y,
  input  logic [CRD_W-1:0] w,
  input  logic [CRD_W-1:0] h,
  output logic [CRD_W:0]   x_end,
  output logic [CRD_W:0]   y_end,
  output logic             empty
);

  localparam logic [CRD_W:0] H_LIM = (CRD_W+1)'(H_RES);
  localparam logic [CRD_W:0] V_LIM = (CRD_W+1)'(V_RES);

  logic [CRD_W:0] xs;
  logic [CRD_W:0] ys;

  always_comb begin
    xs    = {1'b0, x} + {1'b0, w};
    ys    = {1'b0, y} + {1'b0, h};
    x_end = (xs > H_LIM) ? H_LIM : xs;
    y_end = (ys > V_LIM) ? V_LIM : ys;
    empty = (w == '0) || (h == '0) ||
            ({1'b0, x} >= H_LIM) ||
            ({1'b0, y} >= V_LIM);
  end

endmodule

// File: rtl/frame_fill_sequencer.sv
// Drives the frame buffer write port one pixel per clock
// for CLEAR and clipped RECT commands from software.
module frame_fill_sequencer
  import veggie_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [CRD_W-1:0]  cmd_x,
  input  logic [CRD_W-1:0]  cmd_y,
  input  logic [CRD_W-1:0]  cmd_w,
  input  logic [CRD_W-1:0]  cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  input  logic              abort,
  output logic [ADDR_W-1:0] fb_wraddress,
  output logic [DATA_W-1:0] fb_data,
  output logic              fb_wren,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status
);

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  status_t            status_q, status_d;
  logic [CRD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [CRD_W-1:0]   w_q, w_d, h_q, h_d;
  logic [CRD_W-1:0]   col_q, col_d, row_q, row_d;
  logic [CRD_W:0]     x_end_q, x_end_d;
  logic [CRD_W:0]     y_end_q, y_end_d;
  logic [DATA_W-1:0]  color_q, color_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic [CRD_W-1:0]   sx, sy, sw, sh;
  logic [CRD_W:0]     clip_xe, clip_ye;
  logic               clip_empty;
  logic               col_last, row_last;
  logic [ADDR_W-1:0]  next_row;

  always_comb begin
    sx = x_q;
    sy = y_q;
    sw = w_q;
    sh = h_q;
    if (op_q == OP_CLEAR) begin
      sx = '0;
      sy = '0;
      sw = CRD_W'(H_RES);
      sh = CRD_W'(V_RES);
    end
  end

  rect_clipper u_clip (
    .x     (sx),
    .y     (sy),
    .w     (sw),
    .h     (sh),
    .x_end (clip_xe),
    .y_end (clip_ye),
    .empty (clip_empty)
  );

  assign col_last = (({1'b0, col_q} + 11'd1) == x_end_q);
  assign row_last = (({1'b0, row_q} + 11'd1) == y_end_q);
  assign next_row = row_base_q + ADDR_W'(H_RES);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    status_d   = status_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    col_d      = col_q;
    row_d      = row_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    color_d    = color_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = op_t'(cmd_op);
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          state_d = SETUP;
        end
      end
      SETUP: begin
        x_d     = sx;
        y_d     = sy;
        x_end_d = clip_xe;
        y_end_d = clip_ye;
        if (clip_empty) begin
          status_d = ST_EMPTY;
          state_d  = DONE;
        end else begin
          col_d      = sx;
          row_d      = sy;
          row_base_d = row_base(sy);
          addr_d     = row_base(sy) + ADDR_W'(sx);
          status_d   = ST_OK;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (abort) begin
          status_d = ST_ABORT;
          state_d  = DONE;
        end else if (col_last && row_last) begin
          status_d = ST_OK;
          state_d  = DONE;
        end else if (col_last) begin
          col_d      = x_q;
          row_d      = row_q + 10'd1;
          row_base_d = next_row;
          addr_d     = next_row + ADDR_W'(x_q);
        end else begin
          col_d  = col_q + 10'd1;
          addr_d = addr_q + 19'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      op_q       <= OP_CLEAR;
      status_q   <= ST_OK;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      color_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      status_q   <= status_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      col_q      <= col_d;
      row_q      <= row_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      color_q    <= color_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign fb_wren      = (state_q == FILL);
  assign done         = (state_q == DONE);
  assign status       = done ? status_q : ST_OK;
  assign fb_wraddress = addr_q;
  assign fb_data      = color_q;

endmodule

// File: tb/tb_frame_fill_sequencer.sv
// Randomized and directed checks of frame_fill_sequencer
// against a pixel-list reference model.
module tb_frame_fill_sequencer;
  import veggie_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [9:0]  cmd_x = '0, cmd_y = '0;
  logic [9:0]  cmd_w = '0, cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic        abort = 1'b0;
  logic [18:0] fb_wraddress;
  logic [7:0]  fb_data;
  logic        fb_wren;
  logic        busy;
  logic        done;
  logic [1:0]  status;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  frame_fill_sequencer dut (
    .Clk          (clk),
    .Reset_n      (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .cmd_w        (cmd_w),
    .cmd_h        (cmd_h),
    .cmd_color    (cmd_color),
    .abort        (abort),
    .fb_wraddress (fb_wraddress),
    .fb_data      (fb_data),
    .fb_wren      (fb_wren),
    .busy         (busy),
    .done         (done),
    .status       (status)
  );

  // every pixel the command should touch, in raster order
  task automatic build(input bit op, input int x, input int y,
                       input int w, input int h);
    int x1, y1;
    exp_q.delete();
    if (!op) begin
      x = 0; y = 0; w = 640; h = 480;
    end
    x1 = (x + w > 640) ? 640 : x + w;
    y1 = (y + h > 480) ? 480 : y + h;
    for (int yy = y; yy < y1; yy++)
      for (int xx = x; xx < x1; xx++)
        exp_q.push_back(yy * 640 + xx);
  endtask

  task automatic issue(input bit op, input int x, input int y,
                       input int w, input int h,
                       input logic [7:0] c, input bit hold);
    @(negedge clk);
    cmd_op = op; cmd_x = 10'(x); cmd_y = 10'(y);
    cmd_w = 10'(w); cmd_h = 10'(h); cmd_color = c;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL accept: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // called just after the accept edge; cycle k=1 is SETUP
  task automatic collect(input string nm, input int abort_at,
                         input bit abort_setup,
                         input logic [7:0] c);
    int nw, done_k, bad_a, bad_d, exp_n;
    bit got, gap;
    logic [1:0] st, exp_st;
    nw = 0; done_k = 0; got = 0; gap = 0;
    bad_a = -1; bad_d = -1; st = 2'b11;
    exp_st = (exp_q.size() == 0) ? 2'b01 : 2'b00;
    if (abort_at > 0 && abort_at < exp_q.size()) begin
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      exp_st = 2'b10;
    end
    exp_n = exp_q.size();
    for (int k = 1; k <= 400000 && !got; k++) begin
      @(negedge clk);
      if (fb_wren === 1'b1) begin
        if (k != nw + 2) gap = 1;
        if (nw < exp_n && bad_a < 0 && fb_wraddress !== 19'(exp_q[nw]))
          bad_a = nw;
        if (bad_d < 0 && fb_data !== c) bad_d = nw;
        nw++;
      end
      if (done === 1'b1) begin
        got = 1; done_k = k; st = status;
      end
      abort = (abort_at > 0 && k == abort_at + 1) ||
              (abort_setup && k == 0);
    end
    abort = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s timeout: done never seen, required within budget", nm);
    end
    n_cmp++;
    if (nw != exp_n) begin
      n_bad++;
      $display("FAIL %s writes: got %0d required %0d", nm, nw, exp_n);
    end
    n_cmp++;
    if (bad_a >= 0) begin
      n_bad++;
      $display("FAIL %s addr: pixel %0d wrong, required %0d",
               nm, bad_a, exp_q[bad_a]);
    end
    n_cmp++;
    if (bad_d >= 0 || gap) begin
      n_bad++;
      $display("FAIL %s data/gap: bad_data_idx=%0d gap=%0b required -1/0",
               nm, bad_d, gap);
    end
    n_cmp++;
    if (done_k != exp_n + 2) begin
      n_bad++;
      $display("FAIL %s done_cycle: got %0d required %0d",
               nm, done_k, exp_n + 2);
    end
    n_cmp++;
    if (st !== exp_st) begin
      n_bad++;
      $display("FAIL %s status: got %b required %b", nm, st, exp_st);
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle: ready=%b done=%b busy=%b required 1/0/0",
               nm, cmd_ready, done, busy);
    end
  endtask

  task automatic run(input string nm, input bit op,
                     input int x, input int y, input int w, input int h,
                     input logic [7:0] c, input int abort_at,
                     input bit abort_setup);
    build(op, x, y, w, h);
    issue(op, x, y, w, h, c, 1'b0);
    collect(nm, abort_at, abort_setup, c);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || fb_wren !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || status !== 2'b00 ||
        fb_wraddress !== '0 || fb_data !== '0) begin
      n_bad++;
      $display("FAIL reset: ready=%b wren=%b busy=%b done=%b st=%b a=%0d d=%0h required 1/0/0/0/00/0/0",
               cmd_ready, fb_wren, busy, done, status, fb_wraddress, fb_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_fill;
    issue(1'b1, 5, 5, 20, 20, 8'hC3, 1'b0);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (fb_wren !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid pre: wren=%b required 1", fb_wren);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (fb_wren !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid: wren=%b done=%b busy=%b required 0/0/0",
               fb_wren, done, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || fb_wren !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_release: ready=%b wren=%b done=%b required 1/0/0",
               cmd_ready, fb_wren, done);
    end
  endtask

  task automatic test_directed;
    run("rect_basic", 1'b1, 10, 2, 3, 2, 8'h5A, 0, 1'b0);
    run("rect_corner", 1'b1, 638, 479, 5, 5, 8'h11, 0, 1'b0);
    run("rect_w0", 1'b1, 10, 10, 0, 4, 8'h22, 0, 1'b0);
    run("rect_x700", 1'b1, 700, 10, 4, 4, 8'h33, 0, 1'b0);
    run("rect_y480", 1'b1, 0, 480, 4, 4, 8'h34, 0, 1'b0);
    run("rect_bottom", 1'b1, 0, 470, 700, 30, 8'h44, 0, 1'b0);
    run("clear_part", 1'b0, 99, 99, 9, 9, 8'h03, 1500, 1'b0);
  endtask

  task automatic test_abort;
    run("abort_4x4", 1'b1, 100, 100, 4, 4, 8'h77, 4, 1'b0);
    run("abort_setup", 1'b1, 20, 30, 3, 3, 8'h78, 0, 1'b1);
  endtask

  task automatic test_back_to_back;
    build(1'b1, 200, 50, 4, 4);
    issue(1'b1, 200, 50, 4, 4, 8'h9E, 1'b1);
    cmd_x = 10'd300; cmd_y = 10'd60;
    cmd_w = 10'd2; cmd_h = 10'd3; cmd_color = 8'h4B;
    collect("b2b_first", 4, 1'b0, 8'h9E);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    build(1'b1, 300, 60, 2, 3);
    collect("b2b_second", 0, 1'b0, 8'h4B);
  endtask

  task automatic test_random;
    int x, y, w, h, a, area;
    for (int i = 0; i < 25; i++) begin
      x = $urandom_range(700);
      y = $urandom_range(520);
      w = $urandom_range(24);
      h = $urandom_range(24);
      build(1'b1, x, y, w, h);
      area = exp_q.size();
      a = 0;
      if (area > 1 && $urandom_range(3) == 0)
        a = $urandom_range(area - 1, 1);
      run($sformatf("rand%0d", i), 1'b1, x, y, w, h,
          8'($urandom), a, 1'($urandom_range(1)));
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_abort;
    test_back_to_back;
    test_reset_mid_fill;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
